// File: rtl/jpeg_cone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_cone_pkg
//  Description : Shared types and helpers for the JPEG qualifier-cone pipe.
//                Holds the per-beat function select encoding, the supported
//                pipeline depth limit and the single-lane cone function.
//  Revision    : 1.0 - initial parametrised pipelined release
// ============================================================================
package jpeg_cone_pkg;

   typedef enum logic [1:0] {
      MODE_AOI  = 2'd0,   // legacy AOI322 qualifier
      MODE_OAI  = 2'd1,
      MODE_AND  = 2'd2,
      MODE_RSVD = 2'd3
   } cone_mode_e;

   localparam int unsigned MAX_STAGES = 4;

   // One lane of the cone: g = AND of the lane's terms, o = OR of the same
   // terms, a/b = lane qualifiers. The reserved encoding yields 0.
   function automatic logic cone_lane(input cone_mode_e mode,
                                      input logic g,
                                      input logic o,
                                      input logic a,
                                      input logic b);
      logic y;
      case (mode)
         MODE_AOI: y = ~g & a & b;
         MODE_OAI: y = ~(o & (a | b));
         MODE_AND: y = g;
         default:  y = 1'b0;
      endcase
      return y;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_cone_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_cone_pipe_stage
//  Description : One elastic valid/ready register slice.
//                Ports: clk, rst_n (async active-low), in_valid/in_data/
//                in_ready upstream side, out_valid/out_data/out_ready
//                downstream side.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_cone_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   always_comb begin
      // An empty slot always accepts, so bubbles never block upstream.
      in_ready = ~valid_q | out_ready;
      valid_d  = valid_q;
      data_d   = data_q;
      if (in_ready) begin
         valid_d = in_valid;
         // Data only moves with a real beat: keeps the output at its reset
         // value of zero until the first beat arrives.
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/jpeg_aoi_cone_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_aoi_cone_pipe
//  Description : WIDTH-lane qualifier cone (AOI/OAI/AND, selected per beat)
//                followed by a STAGES-deep elastic pipeline and a saturating
//                count of non-zero result beats.
//                Ports: clk, rst_n (async active-low); in_valid/in_ready with
//                and_grp, qual_a, qual_b, mode as the input beat;
//                out_valid/out_ready with out_y as the result beat;
//                clr_cnt (sync clear) and hit_cnt.
//  Revision    : 1.0 - initial parametrised pipelined release
// ============================================================================
module jpeg_aoi_cone_pipe
   import jpeg_cone_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int N_AND  = 3,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_AND*WIDTH-1:0] and_grp,
   input  logic [WIDTH-1:0]       qual_a,
   input  logic [WIDTH-1:0]       qual_b,
   input  logic [1:0]             mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_y,
   input  logic                   clr_cnt,
   output logic [CNT_W-1:0]       hit_cnt
);

   // Depth is held inside the supported range so an out-of-range override
   // still builds a sane pipe.
   localparam int c_depth = (STAGES < 1) ? 1 :
                            (STAGES > int'(MAX_STAGES)) ? int'(MAX_STAGES) : STAGES;

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_o;
   logic [WIDTH-1:0] w_y;

   // Term j of lane i sits at bit j*WIDTH+i.
   always_comb begin
      w_g = '1;
      w_o = '0;
      w_y = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < N_AND; j++) begin
            w_g[i] = w_g[i] & and_grp[j*WIDTH+i];
            w_o[i] = w_o[i] | and_grp[j*WIDTH+i];
         end
         w_y[i] = cone_lane(cone_mode_e'(mode), w_g[i], w_o[i], qual_a[i], qual_b[i]);
      end
   end

   // Index k is the input side of stage k; index c_depth is the pipe output.
   logic [c_depth:0]            w_valid;
   logic [c_depth:0]            w_ready;
   logic [c_depth:0][WIDTH-1:0] w_data;

   assign w_valid[0]       = in_valid;
   assign w_data[0]        = w_y;
   assign w_ready[c_depth] = out_ready;
   assign in_ready         = w_ready[0];

   for (genvar k = 0; k < c_depth; k++) begin : g_stage
      jpeg_cone_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (w_valid[k]),
         .in_data   (w_data[k]),
         .in_ready  (w_ready[k]),
         .out_valid (w_valid[k+1]),
         .out_data  (w_data[k+1]),
         .out_ready (w_ready[k+1])
      );
   end

   assign out_valid = w_valid[c_depth];
   assign out_y     = w_data[c_depth];

   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

   // Clear has priority over a same-cycle increment; the count sticks at
   // all-ones rather than wrapping.
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if (clr_cnt) begin
         hit_cnt_d = '0;
      end else if (out_valid && out_ready && (out_y != '0) && (hit_cnt_q != '1)) begin
         hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign hit_cnt = hit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_aoi_cone_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_aoi_cone_pipe
//  Description : Self-checking bench for jpeg_aoi_cone_pipe (8 lanes, 3 AND
//                terms, 2 stages, 3-bit hit counter). Vector table with
//                hand-derived results, scoreboard queue for the output
//                stream, reference hit counter, and directed sequences for
//                latency, backpressure, release, counter and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_aoi_cone_pipe;

   localparam int WIDTH  = 8;
   localparam int N_AND  = 3;
   localparam int STAGES = 2;
   localparam int CNT_W  = 3;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [N_AND*WIDTH-1:0] and_grp;
   logic [WIDTH-1:0]       qual_a;
   logic [WIDTH-1:0]       qual_b;
   logic [1:0]             mode;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_y;
   logic                   clr_cnt;
   logic [CNT_W-1:0]       hit_cnt;

   jpeg_aoi_cone_pipe #(
      .WIDTH  (WIDTH),
      .N_AND  (N_AND),
      .STAGES (STAGES),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .and_grp   (and_grp),
      .qual_a    (qual_a),
      .qual_b    (qual_b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .clr_cnt   (clr_cnt),
      .hit_cnt   (hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N_AND*WIDTH-1:0] grp;
      logic [WIDTH-1:0]       a;
      logic [WIDTH-1:0]       b;
      logic [1:0]             md;
      logic [WIDTH-1:0]       y;
   } vec_t;

   localparam int N_VEC = 13;
   vec_t vecs [N_VEC];

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int pops_base;

   logic [WIDTH-1:0] sb [$];
   logic [WIDTH-1:0] cur_exp;
   int               cnt_model = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_y = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output monitor: handshakes seen here complete at the next rising edge.
   always @(negedge clk) begin
      logic [WIDTH-1:0] exp_y;
      logic             nz_fire;
      if (!rst_n) begin
         sb.delete();
         cnt_model  = 0;
         prev_stall = 1'b0;
      end else begin
         nz_fire = 1'b0;
         chk("hit_cnt_track", 32'(hit_cnt), 32'(cnt_model));
         if (prev_stall && out_valid) begin
            chk("stall_stable", 32'(out_y), 32'(prev_y));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h expected no beat (t=%0t)", out_y, $time);
            end else begin
               exp_y = sb.pop_front();
               pops++;
               chk("out_y_stream", 32'(out_y), 32'(exp_y));
               nz_fire = (exp_y != '0);
            end
         end
         if (clr_cnt) begin
            cnt_model = 0;
         end else if (nz_fire && cnt_model < 7) begin
            cnt_model++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(cur_exp);
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = out_y;
      end
   end

   task automatic drive(input vec_t v);
      and_grp = v.grp;
      qual_a  = v.a;
      qual_b  = v.b;
      mode    = v.md;
      cur_exp = v.y;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input vec_t v);
      bit done;
      done = 1'b0;
      drive(v);
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected accept within 200 cycles");
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) begin
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // and_grp = {term2, term1, term0}; results derived by hand
      vecs[0]  = '{24'h010101, 8'hFF, 8'hFF, 2'd0, 8'hFE};
      vecs[1]  = '{24'h0FFF3C, 8'hAA, 8'h00, 2'd2, 8'h0C};
      vecs[2]  = '{24'h0FFF3C, 8'hAA, 8'h00, 2'd1, 8'h55};
      vecs[3]  = '{24'h0FFF3C, 8'hAA, 8'h00, 2'd3, 8'h00};
      vecs[4]  = '{24'h0FFF3C, 8'hAA, 8'h00, 2'd0, 8'h00};
      vecs[5]  = '{24'hF0CCAA, 8'hFF, 8'h0F, 2'd0, 8'h0F};
      vecs[6]  = '{24'hF0CCAA, 8'hFF, 8'h0F, 2'd1, 8'h01};
      vecs[7]  = '{24'hF0CCAA, 8'hFF, 8'h0F, 2'd2, 8'h80};
      vecs[8]  = '{24'h000000, 8'h33, 8'h55, 2'd0, 8'h11};
      vecs[9]  = '{24'h000000, 8'h33, 8'h55, 2'd1, 8'hFF};
      vecs[10] = '{24'hFFFFFF, 8'h12, 8'h34, 2'd1, 8'hC9};
      vecs[11] = '{24'hFFFFFF, 8'h12, 8'h34, 2'd2, 8'hFF};
      vecs[12] = '{24'hFFFFFF, 8'hFF, 8'hFF, 2'd3, 8'h00};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      and_grp   = '0;
      qual_a    = '0;
      qual_b    = '0;
      mode      = 2'd0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      cur_exp   = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_y", 32'(out_y), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mode 0 and two-cycle latency
      pulse_clr();
      drive(vecs[0]);
      in_valid = 1'b1;
      @(negedge clk);
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t1_lat_c1_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("t1_lat_c2_valid", 32'(out_valid), 32'd1);
      chk("t1_out_y", 32'(out_y), 32'h0FE);
      @(posedge clk);
      #1;
      chk("t1_hit_cnt", 32'(hit_cnt), 32'd1);

      // Reserved mode never counts
      pulse_clr();
      send(vecs[3]);
      send(vecs[12]);
      drain();
      chk("t2_rsvd_no_count", 32'(hit_cnt), 32'd0);

      // Whole table streamed back-to-back
      for (int i = 0; i < N_VEC; i++) begin
         send(vecs[i]);
      end
      drain();

      // Backpressure: fill both slots, then stall a third beat
      pulse_clr();
      pops_base = pops;
      out_ready = 1'b0;
      send(vecs[0]);
      send(vecs[5]);
      drive(vecs[6]);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_in_ready_low", 32'(in_ready), 32'd0);
         chk("t3_out_valid_held", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      // Release with the pipe full and a beat waiting
      out_ready = 1'b1;
      #1;
      chk("t4_in_ready_release", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t4_still_valid", 32'(out_valid), 32'd1);
      chk("t4_next_y", 32'(out_y), 32'h00F);
      send(vecs[7]);
      send(vecs[8]);
      send(vecs[9]);
      drain();
      chk("t3_beat_count", 32'(pops - pops_base), 32'd6);

      // Counter saturation and clear priority
      pulse_clr();
      for (int i = 0; i < 10; i++) begin
         send(vecs[0]);
      end
      drain();
      chk("t5_saturate", 32'(hit_cnt), 32'd7);
      drive(vecs[0]);
      in_valid = 1'b1;
      clr_cnt  = 1'b1;
      @(negedge clk);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
      chk("t5_clear", 32'(hit_cnt), 32'd0);
      drain();
      chk("t5_after_clear", 32'(hit_cnt), 32'd1);
      send(vecs[0]);
      @(posedge clk);
      #1;
      chk("t5_out_valid", 32'(out_valid), 32'd1);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      chk("t5_clr_wins", 32'(hit_cnt), 32'd0);
      drain();

      // Asynchronous reset with two beats in flight
      out_ready = 1'b0;
      send(vecs[5]);
      send(vecs[7]);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_out_y", 32'(out_y), 32'd0);
      chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
      chk("t6_rst_hit_cnt", 32'(hit_cnt), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t6_no_ghost", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(vecs[10]);
      drain();
      chk("t6_post_reset_cnt", 32'(hit_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jpeg_aoi_cone_pipe.md
Name: jpeg_aoi_cone_pipe

Overview:
- Parametrised, pipelined successor to the single-bit AOI322 qualifier cone in the JPEG datapath.
- Evaluates the qualifier function over WIDTH parallel lanes; the function is selected per beat.
- Carries results through a STAGES-deep elastic valid/ready pipeline.
- Keeps a saturating count of non-zero result beats for timing-closure and debug visibility.

Parameters:
- WIDTH, 8, lanes per beat (1..64)
- N_AND, 3, terms in the AND group per lane (2..8)
- STAGES, 2, pipeline register depth (1..4)
- CNT_W, 16, hit counter width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  pipeline can accept a beat
- and_grp  input  N_AND*WIDTH  AND-group terms; bit j*WIDTH+i is term j of lane i
- qual_a  input  WIDTH  qualifier A per lane
- qual_b  input  WIDTH  qualifier B per lane
- mode  input  2  function select, sampled with the beat
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- out_y  output  WIDTH  result per lane
- clr_cnt  input  1  synchronous clear of hit_cnt
- hit_cnt  output  CNT_W  saturating count of accepted non-zero beats

Behaviour:
- Lane function, combinational at the input and captured into stage 0. Here g_i = AND of the N_AND terms of lane i, and o_i = OR of the same terms.
  - mode 0 (AOI, legacy): y_i = ~g_i & a_i & b_i
  - mode 1 (OAI): y_i = ~(o_i & (a_i | b_i))
  - mode 2 (AND pass): y_i = g_i
  - mode 3: reserved; y = 0
- Pipeline stages k = 0..STAGES-1 each hold a valid bit v[k] and WIDTH data bits.
  - ready[STAGES] = out_ready.
  - ready[k] = ~v[k] | ready[k+1].
  - in_ready = ready[0].
- Stage k loads when ready[k] is 1:
  - for k = 0: v[0] <= in_valid, data <= f(inputs);
  - for k > 0: v[k] <= v[k-1], data <= data[k-1].
- A stage holds its contents when ready[k] is 0.
- out_valid = v[STAGES-1]; out_y = data[STAGES-1].
- Latency is exactly STAGES cycles from input acceptance to out_valid while out_ready is held high. Throughput is 1 beat/cycle.
- Backpressure:
  - With out_ready low, a stalled out_y is stable and no beat is lost or duplicated.
  - in_ready drops once all STAGES slots are full.
  - Up to STAGES beats are buffered.
- Bubbles compress: an invalid stage is always overwritten.
- Simultaneous out_ready rising and in_valid with a full pipe: the input is accepted the same cycle (the combinational ready chain permits it).
- hit_cnt:
  - increments on out_valid & out_ready & (out_y != 0);
  - saturates at 2^CNT_W-1;
  - clr_cnt forces 0 and wins over a same-cycle increment.
- Reset, asynchronous and active-low:
  - all v[k] = 0, all data = 0, hit_cnt = 0;
  - hence out_valid = 0, out_y = 0, in_ready = 1.
  - Reset mid-operation discards all in-flight beats. No beat emerges after reset release until a new input is accepted.
- Data in invalid stages is don't-care internally. out_y must nevertheless be 0 after reset until the first beat arrives.

Decomposition:
- Package jpeg_cone_pkg:
  - typedef cone_mode_e: MODE_AOI = 0, MODE_OAI = 1, MODE_AND = 2, MODE_RSVD = 3;
  - localparam MAX_STAGES = 4;
  - lane-function helper.
- One sub-module, jpeg_cone_pipe_stage: a single elastic register slice (valid, ready, data). It is instantiated STAGES times through a generate loop.

Test Plan:
1. Mode 0 function check:
   - Stimulus, lanes 0..7: and_grp all 1s on lane 0, all 0s elsewhere; qual_a = 0xFF; qual_b = 0xFF; STAGES = 2; out_ready = 1.
   - Required: out_y = 0xFE exactly 2 cycles after acceptance, and hit_cnt = 1.
2. Modes 1/2/3 on one input vector:
   - Stimulus: and_grp = {0x0F, 0xFF, 0x3C}; a = 0xAA; b = 0x00.
   - Required: mode 2 gives out_y = 0x0C. Mode 1 gives out_y = 0x55. Mode 3 gives out_y = 0x00 and hit_cnt does not change.
3. Backpressure:
   - Stimulus: stream 6 beats with out_ready = 0.
   - Required: in_ready falls after 2 accepts. After out_ready rises, all 6 beats emerge in order with none lost or duplicated, and a stalled out_y stays stable.
4. Full pipe with simultaneous release:
   - Stimulus: pipe full, out_ready rises while in_valid = 1.
   - Required: one beat out and one beat in during the same cycle, with in_ready = 1 that cycle.
5. Counter:
   - Stimulus: with CNT_W = 3, send 10 non-zero beats, then assert clr_cnt in the same cycle as an 11th non-zero beat is accepted.
   - Required: hit_cnt saturates at 7, then reads 0 after the clear.
6. Reset:
   - Stimulus: assert rst_n = 0 asynchronously with 2 beats in flight.
   - Required: out_valid = 0 and out_y = 0 immediately. After release, out_valid stays 0 until a new input is accepted.
